lsu: RTL
========

# lsu

Load/store unit between the pipeline MEM stage and `data_mem`. It does four things:
- converts a held MEM-stage load/store request into a single VALID/READY transaction on the `data_mem` LSU interface;
- generates the byte mask and lane-replicated write data;
- stalls the pipeline until the memory acknowledges;
- aligns and sign/zero-extends returned load data.

Misaligned and illegal accesses are detected here and never reach memory.

## Interface

Parameters:
- `ADDR_W`, default 18: memory byte-address width driven to `data_mem`.

Ports:
- `i_clk`  in  1  clock; all state changes on the rising edge.
- `i_reset`  in  1  synchronous, active-high reset.
- `i_req`  in  1  MEM stage holds a memory op; held stable while `o_stall`=1.
- `i_wren`  in  1  1: store, 0: load.
- `i_funct3`  in  3  RV32I funct3 (LB/LH/LW/LBU/LHU; SB/SH/SW).
- `i_addr`  in  32  effective byte address; bits [31:ADDR_W] ignored.
- `i_wdata`  in  32  store data (rs2).
- `o_ld_data`  out  32  formatted load result.
- `o_stall`  out  1  freeze pipeline.
- `o_misalign`  out  1  misaligned-access flag.
- `o_ADDR`  out  ADDR_W  word-aligned address to memory.
- `o_WDATA`  out  32  lane-replicated write data.
- `o_BMASK`  out  4  byte enables.
- `o_WREN`  out  1  1: write, 0: read.
- `o_VALID`  out  1  request valid.
- `i_RDATA`  in  32  read data; valid in the `i_READY` cycle.
- `i_READY`  in  1  single-cycle completion strobe from memory.

## Operation

Access decode is combinational from `i_funct3`, `i_wren` and `i_addr[1:0]` (`a` = `i_addr[1:0]`).

Legal accesses:
- Loads: funct3 0, 1, 2, 4, 5.
- Stores: funct3 0, 1, 2.
- Any other funct3 is illegal: no memory access, no stall, `o_misalign`=0, `o_ld_data` unchanged.

Misalignment:
- Half accesses (funct3 1 or 5) are misaligned when `a[0]`=1.
- Word accesses (funct3 2) are misaligned when `a`≠0.
- A misaligned access raises `o_misalign`=1 (combinational, IDLE only), issues no access and does not stall.

Byte mask:
- Byte access: `4'b0001 << a`.
- Half access: `4'b0011 << a`.
- Word access: `4'b1111`.
- The same mask is driven for loads.

Write data:
- Byte store: byte replicated ×4.
- Half store: half replicated ×2.
- Word store: unchanged.

Memory address: `o_ADDR` = `{i_addr[ADDR_W-1:2], 2'b00}`.

Load formatting:
- Shift `i_RDATA` right by `8*a`.
- LB: sign-extend from bit 7. LBU: zero-extend from bit 7.
- LH: sign-extend from bit 15. LHU: zero-extend from bit 15.
- LW: unchanged.
- The result is registered into `o_ld_data` on the `i_READY` cycle. The `a` used is the one latched at issue.

FSM:
- IDLE:
  - On `i_req` with a legal, aligned access: latch `o_ADDR`, `o_WDATA`, `o_BMASK`, `o_WREN` and the load format, set `o_VALID`<=1, go to BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - Hold `o_VALID` and all request outputs stable.
  - On `i_READY`: capture load data (loads only), set `o_VALID`<=0, go to DONE.
- DONE:
  - One cycle with `o_VALID`=0. This guarantees `data_mem` sees a fresh VALID rising edge for the next op.
  - `o_stall`=0, so the pipeline advances. Return to IDLE.

Stall:
- `o_stall` = (IDLE & `i_req` & legal & aligned) | BUSY.
- `o_stall` is combinational.

Ignored input: `i_READY` in IDLE or DONE (a stale ack after reset).

Reset, effective on the next edge from any state:
- State goes to IDLE.
- `o_VALID`, `o_WREN`, `o_ADDR`, `o_WDATA`, `o_BMASK` and `o_ld_data` all go to 0.
- An in-flight access is abandoned and its late `i_READY` is ignored.

## Timing

- Cycle 0 (IDLE, `i_req`=1): `o_stall`=1.
- Cycle 1: `o_VALID`=1.
- If `i_READY`=1 in cycle k≥1, the op is in DONE at cycle k+1:
  - `o_VALID`=0;
  - `o_ld_data` updated;
  - `o_stall`=0.
- Minimum op time is 3 cycles, i.e. 1 memory-latency cycle plus 2.
- Back-to-back ops: the next op's IDLE cycle follows DONE, so VALID is low for at least 2 cycles between transactions.
- `i_req` dropping while in BUSY is a pipeline protocol violation. The FSM completes the access regardless.
- All request outputs are constant for the whole time `o_VALID`=1.

## Test plan

- SW addr 0x104, data 0xDEADBEEF, memory READY after 9 cycles:
  - `o_ADDR`=0x104, `o_BMASK`=4'b1111, `o_WREN`=1;
  - `o_VALID` high for exactly cycles 1–9;
  - `o_stall` high for cycles 0–9 and 0 in cycle 10.
- SB addr 0x7 data 0x000000A5 → `o_BMASK`=4'b1000, `o_WDATA`=0xA5A5A5A5, `o_ADDR`=0x4.
- Loads with `i_RDATA`=0x80F0_7F81:
  - LB a=0 → 0xFFFFFF81; LBU a=0 → 0x00000081.
  - LH a=2 → 0xFFFF80F0; LHU a=2 → 0x000080F0.
  - LB a=1 → 0x0000007F; LW → 0x80F07F81.
- LW addr 0x102, and LH addr 0x101:
  - `o_misalign`=1, `o_stall`=0, `o_VALID` stays 0;
  - illegal funct3=3 load → no VALID, no stall, `o_misalign`=0.
- Two back-to-back SW ops with READY latency 1:
  - exactly two VALID rising edges, separated by ≥2 low cycles;
  - each op takes 3 cycles.
- Reset asserted in BUSY:
  - next cycle `o_VALID`=0 and state is IDLE;
  - a subsequent stray `i_READY` does not change `o_ld_data` and raises no stall.

Source files
------------

// File: rtl/lsu.sv
// Load/store unit: turns a held MEM-stage request into one VALID/READY
// transaction on the data_mem port, stalls until READY, and formats load data.

module lsu_lane #(
  parameter int LANE = 0
) (
  input  logic [1:0] size,
  input  logic [1:0] a,
  input  logic [7:0] b_src,
  input  logic [7:0] h_src,
  input  logic [7:0] w_src,
  output logic       mask,
  output logic [7:0] wbyte
);
  localparam logic [1:0] L = LANE[1:0];

  // The caller only latches these for aligned accesses, so a half access
  // enables this lane whenever it sits in the addressed half-word.
  always_comb begin
    mask  = 1'b0;
    wbyte = w_src;
    case (size)
      2'd0: begin
        mask  = (a == L);
        wbyte = b_src;
      end
      2'd1: begin
        mask  = (a[1] == L[1]);
        wbyte = h_src;
      end
      default: mask = 1'b1;
    endcase
  end
endmodule

module lsu #(
  parameter int ADDR_W = 18
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_req,
  input  logic              i_wren,
  input  logic [2:0]        i_funct3,
  input  logic [31:0]       i_addr,
  input  logic [31:0]       i_wdata,
  output logic [31:0]       o_ld_data,
  output logic              o_stall,
  output logic              o_misalign,
  output logic [ADDR_W-1:0] o_ADDR,
  output logic [31:0]       o_WDATA,
  output logic [3:0]        o_BMASK,
  output logic              o_WREN,
  output logic              o_VALID,
  input  logic [31:0]       i_RDATA,
  input  logic              i_READY
);
  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t state, state_nx;

  logic [1:0] a, sz;
  logic       legal, misal, go;
  logic [1:0] a_q;
  logic [2:0] f3_q;
  logic [NUM_LANES-1:0]      mask_nx;
  logic [NUM_LANES-1:0][7:0] wdata_nx;
  logic [31:0] ld_sh, ld_fmt;
  logic        unused_addr;

  assign a           = i_addr[1:0];
  assign sz          = i_funct3[1:0];
  assign unused_addr = ^i_addr[31:ADDR_W];

  always_comb begin
    legal = 1'b0;
    case (i_funct3)
      3'd0, 3'd1, 3'd2: legal = 1'b1;
      3'd4, 3'd5:       legal = ~i_wren;
      default:          legal = 1'b0;
    endcase
  end

  assign misal = ((sz == 2'd1) & a[0]) | ((sz == 2'd2) & (a != 2'd0));
  assign go    = i_req & legal & ~misal;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    lsu_lane #(.LANE(g)) u_lane (
      .size  (sz),
      .a     (a),
      .b_src (i_wdata[7:0]),
      .h_src (i_wdata[8*(g%2) +: 8]),
      .w_src (i_wdata[8*g +: 8]),
      .mask  (mask_nx[g]),
      .wbyte (wdata_nx[g])
    );
  end

  // Formatting uses the offset/funct3 latched at issue, not the live inputs.
  assign ld_sh = i_RDATA >> {a_q, 3'b000};

  always_comb begin
    case (f3_q[1:0])
      2'd0:    ld_fmt = {{24{~f3_q[2] & ld_sh[7]}},  ld_sh[7:0]};
      2'd1:    ld_fmt = {{16{~f3_q[2] & ld_sh[15]}}, ld_sh[15:0]};
      default: ld_fmt = ld_sh;
    endcase
  end

  always_comb begin
    state_nx   = state;
    o_stall    = 1'b0;
    o_misalign = 1'b0;
    case (state)
      S_IDLE: begin
        o_misalign = i_req & legal & misal;
        if (go) begin
          o_stall  = 1'b1;
          state_nx = S_BUSY;
        end
      end
      S_BUSY: begin
        o_stall = 1'b1;
        if (i_READY) state_nx = S_DONE;
      end
      // DONE forces VALID low for a cycle so the next op is a fresh edge.
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) state <= S_IDLE;
    else         state <= state_nx;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_VALID   <= 1'b0;
      o_WREN    <= 1'b0;
      o_ADDR    <= '0;
      o_WDATA   <= '0;
      o_BMASK   <= '0;
      o_ld_data <= '0;
      a_q       <= '0;
      f3_q      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (go) begin
            o_VALID <= 1'b1;
            o_WREN  <= i_wren;
            o_ADDR  <= {i_addr[ADDR_W-1:2], 2'b00};
            o_WDATA <= wdata_nx;
            o_BMASK <= mask_nx;
            a_q     <= a;
            f3_q    <= i_funct3;
          end
        end
        S_BUSY: begin
          if (i_READY) begin
            o_VALID <= 1'b0;
            if (!o_WREN) o_ld_data <= ld_fmt;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
